dwt_row_extender: RTL and testbench
===================================

// Module: dwt_row_extender
// PURPOSE
//  Upstream feeder for the 1-D 9/7 DWT processing unit (Row mode). Takes a raster stream of one
//  sample per beat, splits each line into (even, odd) pairs and adds whole-sample symmetric
//  extension: 2 mirrored pairs before and 2 after every line. Output plugs straight into the
//  processing unit's s_* pair interface.
// PARAMETERS
//  Width            24   signed fixed-point sample width (point position transparent to this block)
//  MaximumSideSize  512  maximum line length N in samples; line counter is $clog2(MaximumSideSize+1) bits
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  s_valid_i      in   1      input sample valid
//  s_ready_o      out  1      input ready
//  s_sof_i        in   1      first sample of frame (qualified by valid&ready)
//  s_eol_i        in   1      last sample of line
//  s_data_i       in   Width  sample x[i]
//  m_valid_o      out  1      output pair valid
//  m_ready_i      in   1      output ready
//  m_sof_o        out  1      first pair of frame
//  m_eol_o        out  1      last pair of line
//  m_data_even_o  out  Width  even member of pair
//  m_data_odd_o   out  Width  odd member of pair
//  err_o          out  1      one-cycle pulse on malformed line
// BEHAVIOUR
//  - Line x[0..N-1], N even, 6 <= N <= MaximumSideSize. Output pair sequence per line (N/2+4 pairs):
//    (x4,x3),(x2,x1),(x0,x1),(x2,x3),...,(x[N-2],x[N-1]),(x[N-2],x[N-3]),(x[N-4],x[N-5]).
//  - m_sof_o=1 on the first pair (x4,x3) of a line whose x0 carried s_sof_i; m_eol_o=1 only on (x[N-4],x[N-5]).
//  - Reset: m_valid_o=0, m_sof_o=0, m_eol_o=0, err_o=0, s_ready_o=0 in reset cycle; FSM=FILL, counters=0.
//  - FSM:
//    FILL:   s_ready_o=1; accept x0..x4 into head regs; after x4 accepted -> HEAD.
//    HEAD:   s_ready_o=0; emit (x4,x3),(x2,x1),(x0,x1),(x2,x3) on consecutive handshakes;
//            x4 kept as pending even; after 4th pair loaded -> STREAM.
//    STREAM: even-index sample -> pending reg (ready=1);
//            odd-index sample accepted only if out reg free (!m_valid_o || m_ready_i),
//            loads (pending,x) into out reg.
//            On odd sample with s_eol_i -> TAIL.
//    TAIL:   s_ready_o=0; emit the 2 suffix pairs from a 5-deep history of last accepted samples
//            (hist[0]=x[N-1]..hist[4]=x[N-5]); after last pair handed off -> FILL.
//  - Output register: contents change only when !m_valid_o || m_ready_i; data and flags held stable while
//    m_valid_o && !m_ready_i. Full throughput: 1 pair per cycle in HEAD/TAIL, 1 pair per 2 input beats in STREAM.
//  - Latency: (x4,x3) valid the cycle after x4 accepted; (x[N-2],x[N-3]) valid the cycle after
//    (x[N-2],x[N-1]) handed off.
//  - Errors (err_o pulses once, 1 cycle after offending beat):
//    s_eol_i at sample count <6 or on an even index (odd N) -> no suffix, nothing more emitted for line, -> FILL;
//    count reaches MaximumSideSize without s_eol_i -> treat that sample as eol (suffix emitted, m_eol_o set);
//    s_sof_i on a sample other than x0 -> partial line dropped (pairs already emitted stay, no suffix),
//    that sample becomes x0 of a new line in FILL.
//  - rst mid-line: abandon line immediately, no suffix, m_valid_o=0 next cycle.
//  - s_sof_i seen during FILL while s_valid_i low is ignored (only handshaked beats count).
// STRUCTURE
//  - dwt_pkg: typedef enum {FILL, HEAD, STREAM, TAIL} ext_state_t; localparam ExtPairs=2; HistDepth=5.
//  - One sub-module: dwt_pair_out_reg (valid/ready register slice for {sof, eol, even, odd});
//    FSM, head regs, history shift and counter stay in this module.
// TESTING
//  1 N=16, x[i]=i<<16, m_ready_i=1 -> 12 pairs (4,3)(2,1)(0,1)(2,3)...(14,15)(14,13)(12,11);
//    sof on pair 0, eol on pair 11.
//  2 Same line, m_ready_i random 50% -> identical 12-pair sequence, no drop/dup; outputs stable while stalled.
//  3 N=6, x=0..5 -> (4,3)(2,1)(0,1)(2,3)(4,5)(4,3)(2,1); eol on last.
//  4 Two back-to-back 16-sample lines, sof only on first x0 -> m_sof_o exactly once; 24 pairs total, eol twice.
//  5 Line with eol at sample 7 (N=7) -> err_o one pulse, no suffix; next line N=16 output correct.
//  6 rst asserted during STREAM of line 1 -> m_valid_o=0 next cycle; following frame (sof) matches test 1.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared types and constants for the DWT row-extension front end.
package dwt_pkg;

  typedef enum logic [1:0] {
    FILL,
    HEAD,
    STREAM,
    TAIL
  } ext_state_t;

  localparam int unsigned ExtPairs  = 2;
  localparam int unsigned HistDepth = 5;

endpackage

// File: rtl/dwt_pair_out_reg.sv
// Valid/ready register slice holding one output pair with its sof/eol flags.
module dwt_pair_out_reg #(
  parameter int unsigned Width = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_sof,
  input  logic             i_eol,
  input  logic [Width-1:0] i_even,
  input  logic [Width-1:0] i_odd,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eol,
  output logic [Width-1:0] o_even,
  output logic [Width-1:0] o_odd,
  output logic             o_free_c
);

  logic             r_valid;
  logic             r_sof;
  logic             r_eol;
  logic [Width-1:0] r_even;
  logic [Width-1:0] r_odd;

  // Slot can take new contents when empty or being drained this cycle.
  assign o_free_c = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
    end else if (o_free_c) begin
      r_valid <= i_load;
      r_sof   <= i_load && i_sof;
      r_eol   <= i_load && i_eol;
    end
  end

  always_ff @(posedge clk) begin
    if (o_free_c && i_load) begin
      r_even <= i_even;
      r_odd  <= i_odd;
    end
  end

  assign o_valid = r_valid;
  assign o_sof   = r_sof;
  assign o_eol   = r_eol;
  assign o_even  = r_even;
  assign o_odd   = r_odd;

endmodule

// File: rtl/dwt_row_extender.sv
// Splits raster lines into (even, odd) pairs and adds two mirrored pairs on each side of the line.
module dwt_row_extender
  import dwt_pkg::*;
#(
  parameter int unsigned Width           = 24,
  parameter int unsigned MaximumSideSize = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             s_sof_i,
  input  logic             s_eol_i,
  input  logic [Width-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_sof_o,
  output logic             m_eol_o,
  output logic [Width-1:0] m_data_even_o,
  output logic [Width-1:0] m_data_odd_o,
  output logic             err_o
);

  localparam int unsigned CntW  = $clog2(MaximumSideSize + 1);
  localparam int unsigned PidxW = 2;

  ext_state_t       r_state;
  ext_state_t       w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic [PidxW-1:0] r_pidx;
  logic [PidxW-1:0] w_pidx_nxt;
  logic             r_line_sof;
  logic             w_line_sof_nxt;
  logic             r_err;
  logic             w_err;

  logic [Width-1:0] r_head [HistDepth];
  logic [Width-1:0] r_hist [HistDepth];
  logic [Width-1:0] r_pend;

  logic             w_ready;
  logic             w_accept;
  logic             w_free;
  logic             w_last;
  logic             w_head_we;
  logic [2:0]       w_head_idx;
  logic             w_pend_we;
  logic             w_load;
  logic             w_ld_sof;
  logic             w_ld_eol;
  logic [Width-1:0] w_ld_even;
  logic [Width-1:0] w_ld_odd;

  assign s_ready_o  = w_ready && !rst;
  assign w_accept   = s_valid_i && s_ready_o;
  assign w_last     = (r_cnt == CntW'(MaximumSideSize - 1));
  // A sample carrying sof always restarts the line as x0.
  assign w_head_idx = s_sof_i ? 3'd0 : r_cnt[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_cnt      <= '0;
      r_pidx     <= '0;
      r_line_sof <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pidx     <= w_pidx_nxt;
      r_line_sof <= w_line_sof_nxt;
      r_err      <= w_err;
    end
  end

  // Head capture, pending even sample and history of the last accepted samples.
  always_ff @(posedge clk) begin
    if (w_head_we) begin
      r_head[w_head_idx] <= s_data_i;
    end
    if (w_pend_we) begin
      r_pend <= s_data_i;
    end
    if (w_accept) begin
      r_hist[0] <= s_data_i;
      for (int i = 1; i < HistDepth; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pidx_nxt     = r_pidx;
    w_line_sof_nxt = r_line_sof;
    w_err          = 1'b0;
    w_ready        = 1'b0;
    w_head_we      = 1'b0;
    w_pend_we      = 1'b0;
    w_load         = 1'b0;
    w_ld_sof       = 1'b0;
    w_ld_eol       = 1'b0;
    w_ld_even      = r_pend;
    w_ld_odd       = s_data_i;

    unique case (r_state)
      FILL: begin
        // x4 goes straight into the output slot, so it waits for the slot to be free.
        w_ready = (r_cnt == CntW'(HistDepth - 1)) ? w_free : 1'b1;
        if (w_accept) begin
          w_head_we = 1'b1;
          w_pend_we = 1'b1;
          if (s_sof_i) begin
            w_line_sof_nxt = 1'b1;
            w_err          = (r_cnt != '0) || s_eol_i;
            w_cnt_nxt      = s_eol_i ? CntW'(0) : CntW'(1);
          end else if (s_eol_i) begin
            w_err     = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            if (r_cnt == '0) begin
              w_line_sof_nxt = 1'b0;
            end
            if (r_cnt == CntW'(HistDepth - 1)) begin
              w_load      = 1'b1;
              w_ld_sof    = r_line_sof;
              w_ld_even   = s_data_i;
              w_ld_odd    = r_head[3];
              w_pidx_nxt  = '0;
              w_state_nxt = HEAD;
            end
            w_cnt_nxt = r_cnt + CntW'(1);
          end
        end
      end

      HEAD: begin
        if (w_free) begin
          w_load = 1'b1;
          unique case (r_pidx)
            2'd0: begin
              w_ld_even = r_head[2];
              w_ld_odd  = r_head[1];
            end
            2'd1: begin
              w_ld_even = r_head[0];
              w_ld_odd  = r_head[1];
            end
            default: begin
              w_ld_even = r_head[2];
              w_ld_odd  = r_head[3];
            end
          endcase
          if (r_pidx == 2'd2) begin
            w_pidx_nxt  = '0;
            w_state_nxt = STREAM;
          end else begin
            w_pidx_nxt = r_pidx + PidxW'(1);
          end
        end
      end

      STREAM: begin
        w_ready = r_cnt[0] ? w_free : 1'b1;
        if (w_accept) begin
          if (s_sof_i) begin
            w_head_we      = 1'b1;
            w_pend_we      = 1'b1;
            w_line_sof_nxt = 1'b1;
            w_err          = 1'b1;
            w_cnt_nxt      = s_eol_i ? CntW'(0) : CntW'(1);
            w_state_nxt    = FILL;
          end else if (!r_cnt[0]) begin
            if (s_eol_i) begin
              w_err       = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = FILL;
            end else begin
              w_pend_we = 1'b1;
              w_cnt_nxt = r_cnt + CntW'(1);
            end
          end else begin
            w_load    = 1'b1;
            w_cnt_nxt = r_cnt + CntW'(1);
            // Running into the maximum line length closes the line as if eol were seen.
            if (s_eol_i || w_last) begin
              w_err       = !s_eol_i;
              w_pidx_nxt  = '0;
              w_state_nxt = TAIL;
            end
          end
        end
      end

      TAIL: begin
        if (w_free) begin
          w_load = 1'b1;
          if (r_pidx == PidxW'(ExtPairs - 1)) begin
            w_ld_even   = r_hist[3];
            w_ld_odd    = r_hist[4];
            w_ld_eol    = 1'b1;
            w_pidx_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = FILL;
          end else begin
            w_ld_even  = r_hist[1];
            w_ld_odd   = r_hist[2];
            w_pidx_nxt = r_pidx + PidxW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  dwt_pair_out_reg #(
    .Width(Width)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_sof   (w_ld_sof),
    .i_eol   (w_ld_eol),
    .i_even  (w_ld_even),
    .i_odd   (w_ld_odd),
    .i_ready (m_ready_i),
    .o_valid (m_valid_o),
    .o_sof   (m_sof_o),
    .o_eol   (m_eol_o),
    .o_even  (m_data_even_o),
    .o_odd   (m_data_odd_o),
    .o_free_c(w_free)
  );

  assign err_o = r_err;

endmodule

// File: tb/tb_dwt_row_extender.sv
// Directed bench for dwt_row_extender: pair order, flags, stalls, malformed lines and reset.
module tb_dwt_row_extender;

  localparam int unsigned Width = 24;
  localparam int unsigned PairW = 2 + 2 * Width;

  logic             clk;
  logic             rst;
  logic             s_valid_i;
  logic             s_ready_o;
  logic             s_sof_i;
  logic             s_eol_i;
  logic [Width-1:0] s_data_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic             m_sof_o;
  logic             m_eol_o;
  logic [Width-1:0] m_data_even_o;
  logic [Width-1:0] m_data_odd_o;
  logic             err_o;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;
  int stall_viol = 0;
  bit rand_ready = 1'b0;

  logic [PairW-1:0] got_q[$];
  logic [PairW-1:0] exp_q[$];
  logic [PairW-1:0] held;
  bit               held_v = 1'b0;

  dwt_row_extender #(
    .Width(Width),
    .MaximumSideSize(512)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_sof_i      (s_sof_i),
    .s_eol_i      (s_eol_i),
    .s_data_i     (s_data_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_sof_o      (m_sof_o),
    .m_eol_o      (m_eol_o),
    .m_data_even_o(m_data_even_o),
    .m_data_odd_o (m_data_odd_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output sink: collect handed-off pairs, count err pulses, watch stalled outputs.
  always @(negedge clk) begin
    logic [PairW-1:0] cur;
    cur = {m_sof_o, m_eol_o, m_data_even_o, m_data_odd_o};
    if (!rst) begin
      if (held_v && (!m_valid_o || cur !== held)) stall_viol++;
      if (m_valid_o && m_ready_i) got_q.push_back(cur);
      if (err_o) err_cnt++;
    end
    held_v = !rst && m_valid_o && !m_ready_i;
    held   = cur;
  end

  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_sample(input logic [Width-1:0] d, input logic sof, input logic eol);
    logic hs;
    int   guard;
    guard     = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_sof_i   = sof;
    s_eol_i   = eol;
    do begin
      @(negedge clk);
      hs = s_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!hs && guard < 1000);
    if (!hs) check_eq("send_timeout", 64'(0), 64'(1));
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
  endtask

  // x[i] = i*scale, eol on the last sample when requested.
  task automatic send_line(input int n, input int scale, input bit sof, input bit eol);
    for (int i = 0; i < n; i++) begin
      send_sample(Width'(i * scale), sof && (i == 0), eol && (i == n - 1));
    end
  endtask

  task automatic push_pairs(input int n, input int ev[], input int od[], input int scale,
                            input bit sof, input bit eol);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({sof && (k == 0), eol && (k == n - 1),
                       Width'(ev[k] * scale), Width'(od[k] * scale)});
    end
  endtask

  task automatic expect_line16(input bit sof, input int scale);
    int ev[] = '{4, 2, 0, 2, 4, 6, 8, 10, 12, 14, 14, 12};
    int od[] = '{3, 1, 1, 3, 5, 7, 9, 11, 13, 15, 13, 11};
    push_pairs(12, ev, od, scale, sof, 1'b1);
  endtask

  task automatic expect_line6(input bit sof);
    int ev[] = '{4, 2, 0, 2, 4, 4, 2};
    int od[] = '{3, 1, 1, 3, 5, 3, 1};
    push_pairs(7, ev, od, 1, sof, 1'b1);
  endtask

  task automatic expect_bad7(input bit sof, input int scale);
    int ev[] = '{4, 2, 0, 2, 4};
    int od[] = '{3, 1, 1, 3, 5};
    push_pairs(5, ev, od, scale, sof, 1'b0);
  endtask

  task automatic wait_pairs(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (8) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, 64'(got_q.size()), 64'(n));
  endtask

  task automatic compare_pairs(input string tag);
    logic [PairW-1:0] g;
    wait_pairs(tag, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_q.size()) ? got_q[k] : '1;
      check_eq($sformatf("%s_pair%0d", tag, k), 64'(g), 64'(exp_q[k]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 64'(m_valid_o), 64'(0));
    check_eq("rst_ready", 64'(s_ready_o), 64'(0));
    check_eq("rst_err",   64'(err_o),     64'(0));
    check_eq("rst_flags", 64'({m_sof_o, m_eol_o}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic N=16 line at full rate.
    err_cnt = 0;
    send_line(16, 1 << 16, 1'b1, 1'b1);
    expect_line16(1'b1, 1 << 16);
    compare_pairs("t1");
    check_eq("t1_err", 64'(err_cnt), 64'(0));

    // Same line with random backpressure.
    rand_ready = 1'b1;
    stall_viol = 0;
    send_line(16, 1 << 16, 1'b1, 1'b1);
    expect_line16(1'b1, 1 << 16);
    compare_pairs("t2");
    rand_ready = 1'b0;
    check_eq("t2_stall_stable", 64'(stall_viol), 64'(0));

    // Minimum line length.
    send_line(6, 1, 1'b1, 1'b1);
    expect_line6(1'b1);
    compare_pairs("t3");

    // Two back-to-back lines, sof only on the first.
    send_line(16, 1 << 16, 1'b1, 1'b1);
    send_line(16, 1 << 16, 1'b0, 1'b1);
    expect_line16(1'b1, 1 << 16);
    expect_line16(1'b0, 1 << 16);
    compare_pairs("t4");

    // Odd-length line: error, no suffix, then a clean line.
    err_cnt = 0;
    send_line(7, 1 << 16, 1'b1, 1'b1);
    send_line(16, 1 << 16, 1'b1, 1'b1);
    expect_bad7(1'b1, 1 << 16);
    expect_line16(1'b1, 1 << 16);
    compare_pairs("t5");
    check_eq("t5_err", 64'(err_cnt), 64'(1));

    // Reset in the middle of a line.
    send_line(9, 1 << 16, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", 64'(s_ready_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_valid_after_rst", 64'(m_valid_o), 64'(0));
    @(posedge clk);
    #1;
    got_q.delete();
    err_cnt = 0;
    send_line(16, 1 << 16, 1'b1, 1'b1);
    expect_line16(1'b1, 1 << 16);
    compare_pairs("t6");
    check_eq("t6_err", 64'(err_cnt), 64'(0));

    // Maximum length without eol: closed as a full line with one err pulse.
    err_cnt = 0;
    send_line(512, 1, 1'b1, 1'b0);
    wait_pairs("t7", 260);
    check_eq("t7_first", 64'((got_q.size() > 0)   ? got_q[0]   : '1), 64'({2'b10, 24'd4,   24'd3}));
    check_eq("t7_p257",  64'((got_q.size() > 257) ? got_q[257] : '1), 64'({2'b00, 24'd510, 24'd511}));
    check_eq("t7_p258",  64'((got_q.size() > 258) ? got_q[258] : '1), 64'({2'b00, 24'd510, 24'd509}));
    check_eq("t7_last",  64'((got_q.size() > 259) ? got_q[259] : '1), 64'({2'b01, 24'd508, 24'd507}));
    check_eq("t7_err", 64'(err_cnt), 64'(1));
    got_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
